// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencer issuing one-at-a-time imem requests into a small fetch queue for decode,
// with redirect flush and kill of in-flight fetches.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic        misaligned_err
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FQ_DEPTH);
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2, KILL_REQ = 3'd3, KILL_WAIT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, kill_addr_q, kill_addr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic          misaligned_q, misaligned_d;
  logic [31:0]   fq_instr [FQ_DEPTH];
  logic [31:0]   fq_pc [FQ_DEPTH];
  logic          accept, push, pop;

  assign imem_req_valid = state_q == REQ || state_q == KILL_REQ;
  // a killed request must keep presenting the address it was raised with until accepted
  assign imem_req_addr  = state_q == KILL_REQ ? kill_addr_q : fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = state_q == WAIT && imem_rsp_valid && !redirect_valid;
  assign id_valid       = count_q != '0;
  assign pop            = id_valid && id_ready && !redirect_valid;
  assign id_instr       = id_valid ? fq_instr[head_q] : '0;
  assign id_pc          = id_valid ? fq_pc[head_q] : '0;
  assign misaligned_err = misaligned_q;

  always_comb begin
    state_d      = state_q;
    kill_addr_d  = kill_addr_q;
    fetch_pc_d   = push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
    head_d       = head_q + AW'(pop);
    tail_d       = tail_q + AW'(push);
    misaligned_d = redirect_valid && redirect_pc[1:0] != 2'b00;
    case (state_q)
      IDLE:      state_d = count_q < FULL ? REQ : IDLE;
      REQ:       state_d = accept ? WAIT : REQ;
      WAIT:      state_d = imem_rsp_valid ? (count_d < FULL ? REQ : IDLE) : WAIT;
      KILL_REQ:  state_d = accept ? KILL_WAIT : KILL_REQ;
      KILL_WAIT: state_d = imem_rsp_valid ? REQ : KILL_WAIT;
      default:   state_d = IDLE;
    endcase
    if (redirect_valid) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      if (state_q == IDLE) state_d = REQ;
      if (state_q == REQ) state_d = accept ? KILL_WAIT : KILL_REQ;
      if (state_q == REQ) kill_addr_d = fetch_pc_q;
      if (state_q == WAIT) state_d = imem_rsp_valid ? REQ : KILL_WAIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      kill_addr_q  <= RESET_PC;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      kill_addr_q  <= kill_addr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fq_instr[tail_q] <= imem_rsp_data;
      fq_pc[tail_q]    <= fetch_pc_q;
    end
  end

  always @(posedge clk) if (!reset) assert (!push || count_q < FULL);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized memory/decode environment checked against a queue-level reference model.
module tb_instr_fetch_unit;
  localparam int FQ = 4;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;

  logic        clk = 0, reset = 1;
  logic        imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] imem_req_addr, imem_rsp_data = 0, redirect_pc = 0, id_instr, id_pc;
  logic        redirect_valid = 0, id_valid, id_ready = 0, misaligned_err;

  instr_fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(FQ)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  ent_t exp_q[$];
  logic [31:0] next_pc, kill_addr, last_live;
  bit inflight, stale, kill_pending, exp_mis, saw_wrap, force_redir, force_idr;
  logic [31:0] force_target;
  int rsp_cnt, p_rdy, p_idr, p_redir, lat_max, accepts, pops;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    next_pc = 0; inflight = 0; stale = 0; kill_pending = 0; exp_mis = 0; rsp_cnt = 0;
  endtask

  task automatic apply_reset();
    reset = 1; imem_req_ready = 0; imem_rsp_valid = 0; redirect_valid = 0; id_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_instr", id_instr, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_mis", misaligned_err, 0);
    reset = 0;
    model_reset();
  endtask

  task automatic step();
    bit acc;
    int size0;
    @(negedge clk);
    size0 = exp_q.size();
    check("id_valid", id_valid, size0 != 0);
    if (size0 != 0) begin
      check("id_pc", id_pc, exp_q[0].pc);
      check("id_instr", id_instr, exp_q[0].instr);
    end
    check("misaligned_err", misaligned_err, exp_mis);
    if (inflight) check("no_req_inflight", imem_req_valid, 0);
    else if (kill_pending) begin
      check("kill_req_valid", imem_req_valid, 1);
      check("kill_req_addr", imem_req_addr, kill_addr);
    end else if (imem_req_valid) begin
      check("req_addr", imem_req_addr, next_pc);
      check("req_gated", size0 < FQ, 1);
    end
    imem_req_ready = $urandom_range(99) < p_rdy;
    id_ready = force_idr || ($urandom_range(99) < p_idr);
    redirect_valid = force_redir || ($urandom_range(99) < p_redir);
    redirect_pc = force_redir ? force_target : $urandom();
    force_redir = 0; force_idr = 0;
    imem_rsp_valid = 0;
    if (inflight) begin
      if (rsp_cnt == 0) begin imem_rsp_valid = 1; imem_rsp_data = $urandom(); end
      else rsp_cnt--;
    end
    acc = imem_req_valid && imem_req_ready;
    if (acc) accepts++;
    exp_mis = redirect_valid && redirect_pc[1:0] != 2'b00;
    if (redirect_valid) begin
      exp_q.delete();
      if (imem_rsp_valid) inflight = 0;
      else if (inflight) stale = 1;
      if (acc) begin inflight = 1; stale = 1; kill_pending = 0; rsp_cnt = $urandom_range(lat_max - 1); end
      else if (imem_req_valid && !kill_pending) begin kill_pending = 1; kill_addr = imem_req_addr; end
      next_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (size0 != 0 && id_ready) begin void'(exp_q.pop_front()); pops++; end
      if (imem_rsp_valid) begin
        inflight = 0;
        if (!stale) begin
          check("no_overflow", size0 < FQ, 1);
          exp_q.push_back('{pc: next_pc, instr: imem_rsp_data});
          next_pc = next_pc + 32'd4;
        end
      end
      if (acc) begin
        if (!kill_pending) begin
          if (last_live == 32'hFFFF_FFFC && imem_req_addr == 32'h0) saw_wrap = 1;
          last_live = imem_req_addr;
        end
        inflight = 1; stale = kill_pending; kill_pending = 0; rsp_cnt = $urandom_range(lat_max - 1);
      end
    end
  endtask

  initial begin
    bit found;
    p_redir = 0; lat_max = 1; p_rdy = 100; p_idr = 100; last_live = 0;
    apply_reset();
    repeat (12) step();
    apply_reset();
    p_idr = 0; accepts = 0;
    repeat (20) step();
    check("full_accepts", accepts, 4);
    check("full_req_idle", imem_req_valid, 0);
    p_idr = 100; pops = 0;
    repeat (20) step();
    check("drain_pops", pops >= 6, 1);
    apply_reset();
    accepts = 0;
    for (int i = 0; i < 20 && accepts < 2; i++) step();
    p_rdy = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i >= 2) begin
        check("stall_valid", imem_req_valid, 1);
        check("stall_addr", imem_req_addr, 32'h8);
      end
    end
    p_rdy = 100; lat_max = 4;
    for (int i = 0; i < 20 && !inflight; i++) step();
    force_redir = 1; force_target = 32'h100;
    step();
    repeat (15) step();
    lat_max = 1; p_idr = 30; found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = exp_q.size() != 0 && inflight && rsp_cnt == 0;
    end
    check("combo_found", found, 1);
    force_redir = 1; force_target = 32'h203; force_idr = 1;
    step();
    step();
    check("mis_pulse", misaligned_err, 1);
    repeat (10) step();
    p_idr = 100; saw_wrap = 0; last_live = 0;
    force_redir = 1; force_target = 32'hFFFF_FFF0;
    repeat (20) step();
    check("pc_wrap", saw_wrap, 1);
    p_rdy = 60; p_idr = 60; p_redir = 4; lat_max = 4; pops = 0;
    repeat (2000) step();
    check("random_progress", pops > 100, 1);
    p_redir = 0; p_idr = 0; lat_max = 8; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = exp_q.size() != 0 && inflight && next_pc != 0;
    end
    check("wait_found", found, 1);
    #2 reset = 1;
    #1;
    check("async_req_valid", imem_req_valid, 0);
    check("async_req_addr", imem_req_addr, 32'h0);
    check("async_id_valid", id_valid, 0);
    check("async_id_pc", id_pc, 0);
    check("async_mis", misaligned_err, 0);
    @(negedge clk);
    imem_rsp_valid = 0; redirect_valid = 0; imem_req_ready = 0;
    @(negedge clk);
    reset = 0;
    model_reset();
    p_rdy = 100; p_idr = 100; lat_max = 2; pops = 0;
    repeat (20) step();
    check("restart_progress", pops > 3, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the decode stage (immediate generator, main/ALU decoders, register file).
- Holds the fetch PC and issues one-at-a-time requests to instruction memory over a valid/ready request channel with a variable-latency response.
- Buffers returned instructions with their PCs in a small fetch queue, presented to decode over a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing the queue and killing in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FQ_DEPTH, 4, fetch queue entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch byte address, word aligned.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  instruction word returned (one-cycle pulse per accepted request).
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  PC redirect from execute (taken branch/JAL/JALR).
- redirect_pc  in  32  redirect target.
- id_valid  out  1  head entry valid to decode.
- id_instr  out  32  instruction to decode.
- id_pc  out  32  PC of id_instr.
- id_ready  in  1  decode accepts head entry.
- misaligned_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset (async assert, sync-released use):
  - fetch_pc = RESET_PC; queue empty; state IDLE.
  - imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, misaligned_err=0.
- FSM states: IDLE, REQ, WAIT, KILL_REQ, KILL_WAIT.
  - IDLE: go to REQ when (count + 0) < FQ_DEPTH, i.e. a free slot exists. First REQ cycle is the first clock after reset deasserts.
  - REQ: imem_req_valid=1, imem_req_addr=fetch_pc.
    - Addr is held stable until accepted (valid & ready).
    - On accept → WAIT.
  - WAIT: on imem_rsp_valid:
    - Push {imem_rsp_data, fetch_pc} into the queue; fetch_pc += 4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
    - Go to REQ if a slot remains after the push (accounting for a same-cycle pop), else IDLE.
  - KILL_REQ: request kept asserted with its original addr until accepted, then → KILL_WAIT.
  - KILL_WAIT: next imem_rsp_valid is discarded (no push), then → REQ.
- Response is never sampled in the accept cycle; earliest response is one cycle after accept.
- Redirect (redirect_valid=1) has priority over every other event that cycle:
  - Queue flushed (count=0). id_valid=0 the next cycle, even if a pop was also requested.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - Any same-cycle imem_rsp_valid is discarded.
  - From REQ (accepted or not) → KILL_WAIT if accepted that cycle, else KILL_REQ. From WAIT → KILL_WAIT unless rsp arrives that cycle (then → REQ).
  - From IDLE → REQ. From KILL_* → stay/advance per the rules above with the new fetch_pc.
- Redirect latency: new target appears on imem_req_addr at N+1 when nothing is in flight.
- misaligned_err: registered, pulses the cycle after a redirect with redirect_pc[1:0]≠0. Fetch proceeds at the aligned address.
- Queue:
  - id_valid = count≠0; id_instr/id_pc are the head entry.
  - Pop on id_valid & id_ready; simultaneous push and pop allowed, count unchanged.
  - Issue gating guarantees no overflow. A push when full is an assertion failure.
- Latency and throughput:
  - Response at cycle M → id_valid at M+1.
  - Steady state is one instruction per (memory latency + 1) cycles.

Test Plan:
- Reset release, imem always ready, 1-cycle latency, id_ready=1 → imem_req_addr sequence 0x0,0x4,0x8; id_pc 0x0,0x4,0x8 with matching id_instr; misaligned_err=0.
- id_ready=0, FQ_DEPTH=4 → exactly 4 requests issued, then imem_req_valid stays 0. Raise id_ready → entries drain in order PC 0x0..0xC and fetch resumes at 0x10.
- imem_req_ready=0 for 5 cycles → imem_req_valid/addr (0x8) stable every cycle; accepted once on ready.
- Redirect to 0x100 while in WAIT for 0x8 → stale 0x8 response dropped, queue empty next cycle, next request addr 0x100, first id_pc 0x100.
- Redirect to 0x203 concurrent with id_valid&id_ready and imem_rsp_valid → no pop/push effect, misaligned_err pulses once, next fetch addr 0x200.
- fetch_pc=0xFFFF_FFFC response → next request addr 0x0000_0000. Reset asserted while in WAIT → outputs cleared immediately, restart at RESET_PC.
